// File: rtl/w450_pkg.sv
// w450 multicycle core: shared opcodes, FSM states and IR field helpers.
// Ports: none (package only).
package w450_pkg;

    localparam int IR_OP_HI = 7;
    localparam int IR_OP_LO = 5;
    localparam int IR_RA_HI = 4;
    localparam int IR_RA_LO = 3;
    localparam int IR_RB_HI = 2;
    localparam int IR_RB_LO = 1;
    localparam int IR_D     = 0;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_NAND = 3'd2,
        OP_LD   = 3'd3,
        OP_ST   = 3'd4,
        OP_BZ   = 3'd5,
        OP_LI   = 3'd6,
        OP_HALT = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_IMM  = 3'd5,
        S_HALT = 3'd6
    } state_e;

    function automatic opcode_e ir_op(input logic [7:0] ir);
        return opcode_e'(ir[IR_OP_HI:IR_OP_LO]);
    endfunction

    function automatic logic [1:0] ir_ra(input logic [7:0] ir);
        return ir[IR_RA_HI:IR_RA_LO];
    endfunction

    function automatic logic [1:0] ir_rb(input logic [7:0] ir);
        return ir[IR_RB_HI:IR_RB_LO];
    endfunction

    function automatic logic ir_d(input logic [7:0] ir);
        return ir[IR_D];
    endfunction

endpackage

// File: rtl/w450_if.sv
// w450 memory bus: fetch port, load port and store port with a shared ready.
// master = core side (drives addresses/store), slave = memory side.
interface w450_if #(
    parameter int N = 8
);

    logic [N-1:0] mem_rd_addr1;
    logic [N-1:0] mem_rd_data1;
    logic [N-1:0] mem_rd_addr2;
    logic [N-1:0] mem_rd_data2;
    logic [N-1:0] mem_wr_addr;
    logic [N-1:0] mem_wr_data;
    logic         mem_wr_en;
    logic         mem_ready;

    modport master (
        output mem_rd_addr1,
        input  mem_rd_data1,
        output mem_rd_addr2,
        input  mem_rd_data2,
        output mem_wr_addr,
        output mem_wr_data,
        output mem_wr_en,
        input  mem_ready
    );

    modport slave (
        input  mem_rd_addr1,
        output mem_rd_data1,
        input  mem_rd_addr2,
        output mem_rd_data2,
        input  mem_wr_addr,
        input  mem_wr_data,
        input  mem_wr_en,
        output mem_ready
    );

endinterface

// File: rtl/w450_alu.sv
// w450 combinational ALU: ADD, SUB (a-b) and NAND, all mod 2^N.
// Ports: i_op opcode, i_a/i_b operands, o_y result (0 for non-ALU ops).
module w450_alu
    import w450_pkg::*;
#(
    parameter int N = 8
) (
    input  opcode_e      i_op,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_y
);

    always_comb begin
        o_y = '0;
        case (i_op)
            OP_ADD:  o_y = i_a + i_b;
            OP_SUB:  o_y = i_a - i_b;
            OP_NAND: o_y = ~(i_a & i_b);
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/w450_mc.sv
// w450 multicycle core: FSM, PC, IR and four-entry register file.
// Ports: clk, reset (sync, active-low), bus (memory master), halted.
module w450_mc
    import w450_pkg::*;
#(
    parameter int           N        = 8,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic   clk,
    input  logic   reset,
    w450_if.master bus,
    output logic   halted
);

    state_e       r_state;
    state_e       w_next;
    logic [N-1:0] r_pc;
    logic [7:0]   r_ir;
    logic [N-1:0] r_reg [4];
    logic [N-1:0] r_ld;

    opcode_e      w_op;
    logic [1:0]   w_ra;
    logic [1:0]   w_rb;
    logic         w_d;
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic [N-1:0] w_alu;
    logic         w_wr_en;

    assign w_op = ir_op(r_ir);
    assign w_ra = ir_ra(r_ir);
    assign w_rb = ir_rb(r_ir);
    assign w_d  = ir_d(r_ir);

    // Both operands are read from the current register values, so a
    // write to ra==rb in EX always sees the pre-write operands.
    assign w_a = r_reg[w_ra];
    assign w_b = r_reg[w_rb];

    w450_alu #(.N(N)) u_alu (
        .i_op (w_op),
        .i_a  (w_a),
        .i_b  (w_b),
        .o_y  (w_alu)
    );

    assign bus.mem_rd_addr1 = r_pc;
    assign bus.mem_rd_addr2 = w_b;
    assign bus.mem_wr_addr  = w_b;
    assign bus.mem_wr_data  = w_a;
    assign bus.mem_wr_en    = w_wr_en;
    assign halted           = (r_state == S_HALT);

    always_comb begin
        w_next  = r_state;
        w_wr_en = 1'b0;
        case (r_state)
            S_IF: begin
                if (bus.mem_ready) w_next = S_ID;
            end
            S_ID: begin
                case (w_op)
                    OP_LD, OP_ST: w_next = S_MEM;
                    OP_LI:        w_next = S_IMM;
                    OP_HALT:      w_next = S_HALT;
                    default:      w_next = S_EX;
                endcase
            end
            S_EX: w_next = S_IF;
            S_MEM: begin
                // Store strobe is held across wait states.
                w_wr_en = (w_op == OP_ST);
                if (bus.mem_ready) begin
                    w_next = (w_op == OP_LD) ? S_WB : S_IF;
                end
            end
            S_WB: w_next = S_IF;
            S_IMM: begin
                if (bus.mem_ready) w_next = S_IF;
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IF;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_ld    <= '0;
            for (int i = 0; i < 4; i++) begin
                r_reg[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IF: begin
                    if (bus.mem_ready) begin
                        r_ir <= bus.mem_rd_data1[7:0];
                        r_pc <= r_pc + 1'b1;
                    end
                end
                S_EX: begin
                    if (w_op == OP_BZ) begin
                        if (w_a == '0) r_pc <= w_b;
                    end else if (w_d) begin
                        r_reg[w_rb] <= w_alu;
                    end else begin
                        r_reg[w_ra] <= w_alu;
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready && w_op == OP_LD) begin
                        r_ld <= bus.mem_rd_data2;
                    end
                end
                S_WB: r_reg[w_ra] <= r_ld;
                S_IMM: begin
                    if (bus.mem_ready) begin
                        r_reg[w_ra] <= bus.mem_rd_data1;
                        r_pc        <= r_pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
